// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - programmable interval timer: prescaled up-count to a captured terminal value
module timer_sequencer #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  periodic,
    input  logic [WIDTH-1:0]      term_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            expiries
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);
    localparam logic [7:0]            EXP_MAX = 8'hFF;

    state_t                  state_q,   state_d;
    logic [WIDTH-1:0]        count_q,   count_d;
    logic [PRESCALE_W-1:0]   psc_cnt_q, psc_cnt_d;
    logic [WIDTH-1:0]        term_sh_q, term_sh_d;
    logic [PRESCALE_W-1:0]   psc_sh_q,  psc_sh_d;
    logic                    per_sh_q,  per_sh_d;
    logic                    done_q,    done_d;
    logic [7:0]              exp_q,     exp_d;

    logic                    tick;
    logic                    at_term;

    // A tick fires on the cycle the prescale counter reaches the captured divisor.
    assign tick    = (psc_cnt_q == psc_sh_q);
    assign at_term = (count_q == term_sh_q);

    assign count    = count_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign expiries = exp_q;

    // Next-state logic: capture on start, advance on ticks, stop overrides terminal handling.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        psc_cnt_d = psc_cnt_q;
        term_sh_d = term_sh_q;
        psc_sh_d  = psc_sh_q;
        per_sh_d  = per_sh_q;
        done_d    = 1'b0;
        exp_d     = exp_q;

        case (state_q)
            ST_IDLE: begin
                // start together with stop is treated as no request at all
                if (start && !stop) begin
                    term_sh_d = term_val;
                    psc_sh_d  = prescale;
                    per_sh_d  = periodic;
                    count_d   = '0;
                    psc_cnt_d = '0;
                    exp_d     = '0;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // abort freezes count, prescaler and expiries where they are
                    state_d = ST_IDLE;
                end else begin
                    psc_cnt_d = tick ? '0 : (psc_cnt_q + PSC_ONE);
                    if (tick) begin
                        if (!at_term) begin
                            count_d = count_q + CNT_ONE;
                        end else begin
                            done_d = 1'b1;
                            if (exp_q != EXP_MAX) begin
                                exp_d = exp_q + 8'd1;
                            end
                            if (per_sh_q) begin
                                count_d = '0;
                            end else begin
                                // one-shot: leave count parked on the terminal value
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            psc_cnt_q <= '0;
            term_sh_q <= '0;
            psc_sh_q  <= '0;
            per_sh_q  <= 1'b0;
            done_q    <= 1'b0;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            psc_cnt_q <= psc_cnt_d;
            term_sh_q <= term_sh_d;
            psc_sh_q  <= psc_sh_d;
            per_sh_q  <= per_sh_d;
            done_q    <= done_d;
            exp_q     <= exp_d;
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// tb/tb_timer_sequencer.sv - self-checking bench for timer_sequencer
module tb_timer_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        periodic;
    logic [15:0] term_val;
    logic [7:0]  prescale;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [7:0]  expiries;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] c;
        logic        b;
        logic        d;
        logic [7:0]  e;
    } exp_t;

    timer_sequencer #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .term_val (term_val),
        .prescale (prescale),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .expiries (expiries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs n edges after the start edge of an uninterrupted run.
    function automatic exp_t run_value(int n, int term, int psc, bit per);
        exp_t r;
        int   q;
        int   t;
        int   l;
        int   p;
        q = psc + 1;
        l = term + 1;
        t = n / q;
        p = l * q;
        if (per) begin
            r.c = 16'(t % l);
            r.b = 1'b1;
            r.d = (n % q == 0) && (t > 0) && (t % l == 0);
            r.e = 8'((t / l) > 255 ? 255 : (t / l));
        end else if (n < p) begin
            r.c = 16'(t);
            r.b = 1'b1;
            r.d = 1'b0;
            r.e = 8'd0;
        end else begin
            r.c = 16'(term);
            r.b = 1'b0;
            r.d = (n == p);
            r.e = 8'd1;
        end
        return r;
    endfunction

    // Same, but a stop sampled at edge s (s>0) freezes the values seen just before it.
    function automatic exp_t ref_model(int n, int term, int psc, bit per, int s);
        exp_t r;
        if (s != 0 && n >= s) begin
            r   = run_value(s - 1, term, psc, per);
            r.b = 1'b0;
            r.d = 1'b0;
        end else begin
            r = run_value(n, term, psc, per);
        end
        return r;
    endfunction

    task automatic check(string tag, exp_t r);
        checks++;
        assert (count === r.c) else begin
            errors++;
            $error("FAIL %s count: got %0h expected %0h", tag, count, r.c);
        end
        checks++;
        assert (busy === r.b) else begin
            errors++;
            $error("FAIL %s busy: got %0b expected %0b", tag, busy, r.b);
        end
        checks++;
        assert (done === r.d) else begin
            errors++;
            $error("FAIL %s done: got %0b expected %0b", tag, done, r.d);
        end
        checks++;
        assert (expiries === r.e) else begin
            errors++;
            $error("FAIL %s expiries: got %0d expected %0d", tag, expiries, r.e);
        end
    endtask

    function automatic exp_t idle_zero();
        exp_t r;
        r.c = 16'd0;
        r.b = 1'b0;
        r.d = 1'b0;
        r.e = 8'd0;
        return r;
    endfunction

    // Reset held for two edges with start asserted; start must be ignored.
    task automatic do_reset(string tag);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rst1"}, idle_zero());
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rst2"}, idle_zero());
        reset = 1'b0;
        start = 1'b0;
    endtask

    // One run: start, then check every cycle; junk on the other inputs while running.
    task automatic run_case(string tag, int term, int psc, bit per, int s, int len);
        int   end_edge;
        int   first_done;
        exp_t r;
        first_done = -1;
        if (s != 0) end_edge = s;
        else if (per) end_edge = 1 << 30;
        else end_edge = (term + 1) * (psc + 1);
        @(negedge clk);
        term_val = 16'(term);
        prescale = 8'(psc);
        periodic = per;
        start    = 1'b1;
        stop     = 1'b0;
        @(posedge clk);
        for (int n = 0; n <= len; n++) begin
            @(negedge clk);
            r = ref_model(n, term, psc, per, s);
            check($sformatf("%s_n%0d", tag, n), r);
            if (done === 1'b1 && first_done < 0) first_done = n;
            if (n == len) break;
            stop     = (s == n + 1);
            start    = (n + 1 <= end_edge) ? 1'($urandom) : 1'b0;
            term_val = 16'($urandom);
            prescale = 8'($urandom);
            periodic = 1'($urandom);
            @(posedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        if (!per && s == 0) begin
            checks++;
            assert (first_done == (term + 1) * (psc + 1)) else begin
                errors++;
                $error("FAIL %s_first_done: got %0d expected %0d", tag, first_done, (term + 1) * (psc + 1));
            end
        end
    endtask

    initial begin
        exp_t r;
        int   term;
        int   psc;
        int   s;
        int   p;
        bit   per;

        reset    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        term_val = 16'd0;
        prescale = 8'd0;

        do_reset("init");

        // one-shot term=3 prescale=0: done only after edge 4, count parked at 3
        run_case("oneshot3", 3, 0, 1'b0, 0, 7);
        checks++;
        assert (count === 16'd3 && expiries === 8'd1) else begin
            errors++;
            $error("FAIL oneshot3_final: got count %0d exp %0d expected 3 and 1", count, expiries);
        end

        // periodic term=1 prescale=1, stopped after edge 12
        run_case("per11", 1, 1, 1'b1, 13, 14);
        checks++;
        assert (expiries === 8'd3) else begin
            errors++;
            $error("FAIL per11_exp: got %0d expected 3", expiries);
        end

        // stop at count 2, then stop coincident with the terminal tick on a rerun
        run_case("stop2", 5, 0, 1'b0, 3, 5);
        checks++;
        assert (count === 16'd2 && busy === 1'b0) else begin
            errors++;
            $error("FAIL stop2_hold: got count %0d busy %0b expected 2 and 0", count, busy);
        end
        run_case("stopterm", 5, 0, 1'b0, 6, 8);
        checks++;
        assert (count === 16'd5 && expiries === 8'd0 && done === 1'b0) else begin
            errors++;
            $error("FAIL stopterm_hold: got count %0d exp %0d done %0b expected 5 0 0", count, expiries, done);
        end

        // start with stop in IDLE: no capture, no run
        @(negedge clk);
        start    = 1'b1;
        stop     = 1'b1;
        term_val = 16'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        r.c = 16'd5;
        r.b = 1'b0;
        r.d = 1'b0;
        r.e = 8'd0;
        check("startstop_idle", r);

        // periodic term=0 prescale=0: done every cycle, expiries saturates
        run_case("per00", 0, 0, 1'b1, 0, 300);
        checks++;
        assert (expiries === 8'd255) else begin
            errors++;
            $error("FAIL per00_sat: got %0d expected 255", expiries);
        end
        do_reset("after_per00");

        // reset mid-run at count 4 with start held high
        @(negedge clk);
        term_val = 16'd10;
        prescale = 8'd0;
        periodic = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("midrun_pre", run_value(4, 10, 0, 1'b0));
        do_reset("midrun");
        @(posedge clk);
        @(negedge clk);
        check("midrun_post", idle_zero());

        // randomized runs
        for (int k = 0; k < 24; k++) begin
            term = $urandom_range(0, 20);
            psc  = $urandom_range(0, 3);
            per  = 1'($urandom);
            p    = (term + 1) * (psc + 1);
            if (per) s = $urandom_range(1, 3 * p + 3);
            else     s = $urandom_range(0, p);
            run_case($sformatf("rnd%0d", k), term, psc, per, s, ((s != 0) ? s : p) + 2);
        end

        // full-range one-shot: done exactly 65536 cycles after the start edge, no wrap
        run_case("full", 65535, 0, 1'b0, 0, 65538);
        checks++;
        assert (count === 16'hFFFF && busy === 1'b0) else begin
            errors++;
            $error("FAIL full_final: got count %0h busy %0b expected ffff and 0", count, busy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
Programmable interval timer controller built around a 16-bit up-count datapath. Captures a terminal value and a prescale divisor on start, then advances the count once per prescaled tick. Emits a one-cycle done pulse at terminal count and runs either one-shot or periodic. Sits beside the counter library as the block that sequences counting for delay, timeout and periodic-event generation.

Parameters:
WIDTH, 16, count and terminal-value width
PRESCALE_W, 8, prescale divisor width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state on the next clk edge
start  input  1  level-sampled; begins a run when in IDLE
stop  input  1  level-sampled; aborts a run
periodic  input  1  captured at start; 1 = auto-reload, 0 = one-shot
term_val  input  WIDTH  terminal count, captured at start
prescale  input  PRESCALE_W  divisor minus one, captured at start
count  output  WIDTH  current count (registered)
busy  output  1  high while state == RUN
done  output  1  one-cycle pulse at terminal tick (registered)
expiries  output  8  saturating number of done pulses since the last start

Behaviour:
- Reset values: state=IDLE, count=0, busy=0, done=0, expiries=0, prescale counter=0, shadow registers=0.
- States: IDLE, RUN. busy = (state==RUN).
- IDLE, start=1 and stop=0: capture term_val, prescale and periodic into shadows; count<=0; prescale counter<=0; expiries<=0; next state RUN. start=1 with stop=1 in IDLE: stay in IDLE, no capture.
- RUN, each cycle: if prescale counter == shadow prescale, this cycle is a tick and the prescale counter clears to 0; otherwise the prescale counter increments.
- Tick with count != shadow term: count <= count+1, modulo 2^WIDTH. No wrap is reachable because term <= 2^WIDTH-1.
- Tick with count == shadow term: done<=1 for exactly one cycle; expiries increments, saturating at 255.
  - periodic=1: count<=0, stay in RUN.
  - periodic=0: state<=IDLE, count holds the terminal value.
- Period from the start-sampling edge to the done edge = (term+1)*(prescale+1) cycles.
- term=0: done on the first tick; count stays 0.
- stop=1 in RUN: state<=IDLE; count, prescale counter and expiries hold; no done.
- stop and terminal tick in the same cycle: stop wins; no done; expiries unchanged.
- start while in RUN is ignored; shadows are not updated mid-run.
- Input changes during RUN have no effect; only the shadows are used.
- reset mid-run: all outputs return to reset values on that edge; a pending done is dropped.
- done is never high in two consecutive cycles unless periodic with term=0 and prescale=0, in which case done stays high every cycle.

Test Plan:
- One-shot, term=3, prescale=0, start pulsed at edge E0 -> count 1,2,3 after E1..E3; done=1 and busy=0 after E4 only; count holds 3; expiries=1.
- Periodic, term=1, prescale=1 -> count sequence 0,0,1,1,0,0,1,1; done pulses after E4, E8, E12; busy stays 1; expiries=3 after E12.
- Stop at count=2 (term=5, prescale=0), then a separate stop coincident with the terminal tick on a rerun -> state IDLE, count holds 2 then 5, done never asserts, expiries=0.
- Periodic, term=0, prescale=0 run for 300 cycles -> done high every cycle; expiries saturates at 255.
- term=16'hFFFF, prescale=0, one-shot -> done exactly 65536 cycles after the start edge; count=16'hFFFF afterwards, no wrap.
- reset asserted mid-run (term=10, count=4) -> next edge: count=0, busy=0, done=0, expiries=0; start ignored while reset=1.
